// File: rtl/dma_bd_fetch_requester_if.sv
// Stream bundle for the BD fetch requester: RQ read requests, RC completions and fetched-BD output.
// The master modport is the requester side; slave is the PCIe/consumer side.
interface dma_bd_fetch_requester_if;
    logic [255:0] m_axis_dma_rq_tdata;
    logic         m_axis_dma_rq_tvalid;
    logic         m_axis_dma_rq_tready;
    logic         m_axis_dma_rq_tlast;
    logic [59:0]  m_axis_dma_rq_tuser;
    logic [7:0]   m_axis_dma_rq_tkeep;

    logic [255:0] s_axis_dma_rc_tdata;
    logic         s_axis_dma_rc_tvalid;
    logic         s_axis_dma_rc_tready;
    logic         s_axis_dma_rc_tlast;
    logic [74:0]  s_axis_dma_rc_tuser;
    logic [7:0]   s_axis_dma_rc_tkeep;

    logic [255:0] m_axis_bd_tdata;
    logic         m_axis_bd_tvalid;
    logic         m_axis_bd_tready;
    logic [1:0]   m_axis_bd_tdest;

    modport master (
        output m_axis_dma_rq_tdata, m_axis_dma_rq_tvalid, m_axis_dma_rq_tlast,
               m_axis_dma_rq_tuser, m_axis_dma_rq_tkeep,
        input  m_axis_dma_rq_tready,
        input  s_axis_dma_rc_tdata, s_axis_dma_rc_tvalid, s_axis_dma_rc_tlast,
               s_axis_dma_rc_tuser, s_axis_dma_rc_tkeep,
        output s_axis_dma_rc_tready,
        output m_axis_bd_tdata, m_axis_bd_tvalid, m_axis_bd_tdest,
        input  m_axis_bd_tready
    );

    modport slave (
        input  m_axis_dma_rq_tdata, m_axis_dma_rq_tvalid, m_axis_dma_rq_tlast,
               m_axis_dma_rq_tuser, m_axis_dma_rq_tkeep,
        output m_axis_dma_rq_tready,
        output s_axis_dma_rc_tdata, s_axis_dma_rc_tvalid, s_axis_dma_rc_tlast,
               s_axis_dma_rc_tuser, s_axis_dma_rc_tkeep,
        input  s_axis_dma_rc_tready,
        input  m_axis_bd_tdata, m_axis_bd_tvalid, m_axis_bd_tdest,
        output m_axis_bd_tready
    );
endinterface

// File: rtl/dma_bd_fetch_requester.sv
// BD fetch requester: walks four BD rings, issues one 32-byte MemRd per BD on RQ,
// reassembles the two-beat RC completion and hands the 256-bit BD to the channel engines.
module dma_bd_fetch_requester (
    input  logic         user_clk,
    input  logic         user_reset,
    input  logic [3:0]   ch_enable,
    input  logic [107:0] bd_base,
    input  logic [107:0] bd_high,
    input  logic [107:0] sw_ptr,
    output logic [107:0] hw_ptr,
    output logic         cpl_err,
    dma_bd_fetch_requester_if.master bus
);
    localparam int unsigned NUM_CH  = 4;
    localparam int unsigned PTR_W   = 27;
    localparam int unsigned HDR_DWW = 160;

    typedef enum logic {REQ_IDLE, REQ_SEND} req_state_t;
    typedef enum logic [1:0] {CPL_HDR, CPL_DATA, CPL_OUT} cpl_state_t;

    req_state_t           req_state;
    cpl_state_t           cpl_state;
    logic [PTR_W-1:0]     ptr_q   [NUM_CH];
    logic [PTR_W-1:0]     base_a  [NUM_CH];
    logic [PTR_W-1:0]     high_a  [NUM_CH];
    logic [PTR_W-1:0]     sw_a    [NUM_CH];
    logic [NUM_CH-1:0]    outstanding;
    logic [NUM_CH-1:0]    pending_c;
    logic [1:0]           last_grant;
    logic [1:0]           req_ch;
    logic [1:0]           grant_c;
    logic [1:0]           cand_c;
    logic                 grant_valid_c;
    logic [7:0]           cpl_tag;
    logic [3:0]           cpl_code;
    logic [HDR_DWW-1:0]   cpl_dw;
    logic                 cpl_hit_c;
    logic                 cpl_bad_c;
    logic                 unused_rc;

    assign unused_rc = ^{bus.s_axis_dma_rc_tuser, bus.s_axis_dma_rc_tkeep};

    // Unpack per-channel ring registers and repack the live pointers.
    always_comb begin
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            base_a[i] = bd_base[i*PTR_W +: PTR_W];
            high_a[i] = bd_high[i*PTR_W +: PTR_W];
            sw_a[i]   = sw_ptr[i*PTR_W +: PTR_W];
            hw_ptr[i*PTR_W +: PTR_W] = ptr_q[i];
            pending_c[i] = ch_enable[i] && (ptr_q[i] != sw_a[i]) && !outstanding[i];
        end
    end

    // Round-robin: first pending channel after last_grant (last_grant itself checked last).
    always_comb begin
        grant_valid_c = 1'b0;
        grant_c       = last_grant;
        cand_c        = last_grant;
        for (int unsigned i = 1; i <= NUM_CH; i++) begin
            cand_c = last_grant + 2'(i);
            if (!grant_valid_c && pending_c[cand_c]) begin
                grant_valid_c = 1'b1;
                grant_c       = cand_c;
            end
        end
    end

    // A completion is usable only for a live read on a real channel tag.
    assign cpl_hit_c = (cpl_tag[7:2] == 6'd0) && outstanding[cpl_tag[1:0]];
    assign cpl_bad_c = (cpl_code != 4'd0) || !bus.s_axis_dma_rc_tlast;

    function automatic logic [255:0] rq_desc(input logic [PTR_W-1:0] ptr, input logic [1:0] ch);
        logic [255:0] d;
        logic [63:0]  addr;
        addr       = 64'({ptr, 5'b0});
        d          = '0;
        d[63:2]    = addr[63:2];
        d[74:64]   = 11'd8;
        d[78:75]   = 4'b0000;
        d[103:96]  = {6'b0, ch};
        return d;
    endfunction

    always_ff @(posedge user_clk) begin
        if (!user_reset) begin
            req_state   <= REQ_IDLE;
            cpl_state   <= CPL_HDR;
            outstanding <= '0;
            last_grant  <= 2'd3;
            req_ch      <= '0;
            for (int unsigned i = 0; i < NUM_CH; i++) ptr_q[i] <= '0;
            cpl_tag     <= '0;
            cpl_code    <= '0;
            cpl_dw      <= '0;
            cpl_err     <= 1'b0;
            bus.m_axis_dma_rq_tdata  <= '0;
            bus.m_axis_dma_rq_tvalid <= 1'b0;
            bus.m_axis_dma_rq_tlast  <= 1'b0;
            bus.m_axis_dma_rq_tuser  <= '0;
            bus.m_axis_dma_rq_tkeep  <= '0;
            bus.s_axis_dma_rc_tready <= 1'b0;
            bus.m_axis_bd_tdata      <= '0;
            bus.m_axis_bd_tvalid     <= 1'b0;
            bus.m_axis_bd_tdest      <= '0;
        end else begin
            cpl_err <= 1'b0;

            // Request side: register descriptor on grant, hold until accepted.
            case (req_state)
                REQ_IDLE: if (grant_valid_c) begin
                    bus.m_axis_dma_rq_tdata  <= rq_desc(ptr_q[grant_c], grant_c);
                    bus.m_axis_dma_rq_tuser  <= 60'hFF;
                    bus.m_axis_dma_rq_tkeep  <= 8'h0F;
                    bus.m_axis_dma_rq_tlast  <= 1'b1;
                    bus.m_axis_dma_rq_tvalid <= 1'b1;
                    req_ch                   <= grant_c;
                    req_state                <= REQ_SEND;
                end
                REQ_SEND: if (bus.m_axis_dma_rq_tready) begin
                    outstanding[req_ch]      <= 1'b1;
                    last_grant               <= req_ch;
                    bus.m_axis_dma_rq_tvalid <= 1'b0;
                    req_state                <= REQ_IDLE;
                end
            endcase

            // Completion side: header beat, data beat, then present the BD.
            case (cpl_state)
                CPL_HDR: begin
                    bus.s_axis_dma_rc_tready <= 1'b1;
                    if (bus.s_axis_dma_rc_tvalid && bus.s_axis_dma_rc_tready) begin
                        cpl_tag   <= bus.s_axis_dma_rc_tdata[71:64];
                        cpl_code  <= bus.s_axis_dma_rc_tdata[15:12];
                        cpl_dw    <= bus.s_axis_dma_rc_tdata[255:96];
                        cpl_state <= CPL_DATA;
                    end
                end
                CPL_DATA: if (bus.s_axis_dma_rc_tvalid && bus.s_axis_dma_rc_tready) begin
                    if (cpl_bad_c || !cpl_hit_c) begin
                        if (cpl_tag[7:2] == 6'd0) outstanding[cpl_tag[1:0]] <= 1'b0;
                        cpl_err   <= cpl_bad_c;
                        cpl_state <= CPL_HDR;
                    end else begin
                        bus.m_axis_bd_tdata      <= {bus.s_axis_dma_rc_tdata[95:0], cpl_dw};
                        bus.m_axis_bd_tdest      <= cpl_tag[1:0];
                        bus.m_axis_bd_tvalid     <= 1'b1;
                        bus.s_axis_dma_rc_tready <= 1'b0;
                        cpl_state                <= CPL_OUT;
                    end
                end
                CPL_OUT: if (bus.m_axis_bd_tready) begin
                    ptr_q[cpl_tag[1:0]] <= (ptr_q[cpl_tag[1:0]] == high_a[cpl_tag[1:0]]) ?
                                           base_a[cpl_tag[1:0]] : ptr_q[cpl_tag[1:0]] + 27'd1;
                    outstanding[cpl_tag[1:0]] <= 1'b0;
                    bus.m_axis_bd_tvalid      <= 1'b0;
                    bus.s_axis_dma_rc_tready  <= 1'b1;
                    cpl_state                 <= CPL_HDR;
                end
                default: cpl_state <= CPL_HDR;
            endcase

            // Disable overrides any advance or request issued this cycle.
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                if (!ch_enable[i]) begin
                    ptr_q[i]       <= base_a[i];
                    outstanding[i] <= 1'b0;
                end
            end
        end
    end
endmodule
